// File: rtl/iir_pkg.sv
// ============================================================================
// iir_pkg -- shared types and helpers for the IIR datapath serial arithmetic.
// Rev 1.0
// ============================================================================
`default_nettype none

package iir_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_alu.sv
// ============================================================================
// nibble_alu -- combinational 4-bit ripple adder with carry in and carry out.
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_alu
    import iir_pkg::*;
(
    input  logic [NIB-1:0] a_i,
    input  logic [NIB-1:0] b_i,
    input  logic           c_i,
    output logic [NIB-1:0] s_o,
    output logic           c_o
);

    logic [NIB:0] w_carry;

    assign w_carry[0] = c_i;

    for (genvar i = 0; i < NIB; i++) begin : g_fa
        assign s_o[i]         = a_i[i] ^ b_i[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = w_carry[NIB];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder -- WIDTH-bit add (optionally subtract, macro SUB_EN)
// computed one nibble per cycle through a single nibble_alu.  Rev 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import iir_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int             N    = WIDTH / NIB;
    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] w_b_sel;
    logic             w_c_sel;
    logic [NIB-1:0]   w_a_nib, w_b_nib, w_nib_s;
    logic             w_nib_co;

`ifdef SUB_EN
    // Subtract as A + ~B + 1; c_in is irrelevant in that mode.
    assign w_b_sel = op ? ~b : b;
    assign w_c_sel = op ? 1'b1 : c_in;
`else
    logic w_op_unused;
    assign w_op_unused = op;
    assign w_b_sel     = b;
    assign w_c_sel     = c_in;
`endif

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                w_a_nib = a_q[k*NIB +: NIB];
                w_b_nib = b_q[k*NIB +: NIB];
            end
        end
    end

    nibble_alu u_alu (
        .a_i (w_a_nib),
        .b_i (w_b_nib),
        .c_i (carry_q),
        .s_o (w_nib_s),
        .c_o (w_nib_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = w_b_sel;
                    carry_d = w_c_sel;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        sum_d[k*NIB +: NIB] = w_nib_s;
                    end
                end
                carry_d = w_nib_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Top nibble: its sum MSB decides signed overflow.
                    c_out_d = w_nib_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (w_nib_s[NIB-1] != a_q[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// tb_nibble_serial_adder -- directed vectors plus handshake/reset sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         op;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic tcin, input logic top, input int hold,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 1);
        a = ta; b = tb_b; c_in = tcin; op = top; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); op = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = c_out; ro = ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_sum_stable", 32'(sum), 32'(rs));
            chk("hold_in_ready_low", 32'(in_ready), 0);
            chk("hold_out_valid_high", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_transfer", 32'(in_ready), 1);
        chk("out_valid_after_transfer", 32'(out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] rs;
        logic         rc, ro;
        int           lat;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`ifdef SUB_EN
        vecs[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
        vecs[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0};
`endif

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_sum", 32'(sum), 0);
        chk("reset_c_out", 32'(c_out), 0);
        chk("reset_ovf", 32'(ovf), 0);

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].op, 0, rs, rc, ro, lat);
            chk($sformatf("vec%0d_latency", v), 32'(lat), N);
            chk($sformatf("vec%0d_sum", v), 32'(rs), 32'(vecs[v].exp_sum));
            chk($sformatf("vec%0d_c_out", v), 32'(rc), 32'(vecs[v].exp_c));
            chk($sformatf("vec%0d_ovf", v), 32'(ro), 32'(vecs[v].exp_ovf));
        end

        // Backpressure for 10 cycles, then an immediate new accept.
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 10, rs, rc, ro, lat);
        chk("bp_sum", 32'(rs), 32'h3333);
        run_op(16'h4000, 16'h0456, 1'b0, 1'b0, 0, rs, rc, ro, lat);
        chk("after_bp_sum", 32'(rs), 32'h4456);

        // Reset in the second RUN cycle.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        repeat (N + 2) @(negedge clk);
        chk("abort_no_late_result", 32'(out_valid), 0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, rs, rc, ro, lat);
        chk("post_abort_sum", 32'(rs), 32'h0002);
        chk("post_abort_latency", 32'(lat), N);

        // Back-to-back with in_valid held high and out_ready held high.
        begin
            logic [W-1:0] exp_q[$];
            int tx, rx, last_t, cyc;
            tx = 0; rx = 0; last_t = -1;
            out_ready = 1'b1;
            c_in = 1'b0; op = 1'b0;
            @(negedge clk);
            for (cyc = 0; cyc < 200 && rx < 4; cyc++) begin
                if (out_valid) begin
                    if (exp_q.size() > 0) chk("b2b_sum", 32'(sum), 32'(exp_q.pop_front()));
                    else chk("b2b_unexpected_result", 32'(out_valid), 0);
                    if (last_t >= 0) chk("b2b_interval", 32'(cyc - last_t), N + 2);
                    last_t = cyc;
                    rx++;
                end
                if (in_ready && tx < 4) begin
                    a = W'(16'h1000 * tx + 16'h0101);
                    b = 16'h0202 + W'(tx);
                    exp_q.push_back(a + b);
                    in_valid = 1'b1;
                    tx++;
                end else if (in_ready) begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("b2b_results", 32'(rx), 4);
            chk("b2b_accepts", 32'(tx), 4);
            repeat (N + 3) @(negedge clk);
            chk("b2b_no_extra_result", 32'(out_valid), 0);
            out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
